alu_result_framer: RTL and testbench

Buffered, parametrised result transmitter for the JSilicon datapath: accepts ALU results over a valid/ready handshake, queues them in a small FIFO, and sends each one over the byte-wide UART transmitter as a framed packet. A packet is an optional header byte, the result split into bytes, and an optional XOR checksum byte. Sits between the ALU result bus and the UART TX, and replaces the fixed free-running INIT/SEND/WAIT sequencer with flow-controlled, lossless, multi-byte transmission.

---
 rtl/alu_result_framer.sv | 142 ++++++++++++++
 tb/tb_alu_result_framer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_framer.sv
// Flow-controlled ALU result transmitter: results are queued in a small FIFO and
// each one is sent to a byte-wide UART as [header] payload bytes [xor checksum].
module alu_result_framer #(
   parameter int         RESULT_W    = 16,
   parameter int         DEPTH       = 4,
   parameter int         MSB_FIRST   = 1,
   parameter int         HEADER_EN   = 1,
   parameter logic [7:0] HEADER_BYTE = 8'hA5,
   parameter int         CHECKSUM_EN = 1,
   localparam int        CW          = $clog2(DEPTH) + 1
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [RESULT_W-1:0] in_data,
   output logic                tx_start,
   output logic [7:0]          tx_data,
   input  logic                tx_busy,
   output logic                frame_done,
   output logic [CW-1:0]       fifo_count,
   output logic                active
);

   localparam int NB      = (RESULT_W + 7) / 8;
   localparam int PW      = NB * 8;
   localparam int AW      = $clog2(DEPTH);
   localparam int F       = HEADER_EN + NB + CHECKSUM_EN;
   localparam int PAY_END = HEADER_EN + NB;
   localparam int IW      = 4;

   typedef enum logic [1:0] {IDLE, SEND, ACK, DONE} state_t;

   state_t          state_reg, state_next;
   logic [PW-1:0]   mem [DEPTH];
   logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0]   count_reg;
   logic [PW-1:0]   shift_reg;
   logic [7:0]      tx_data_reg;
   logic [7:0]      csum_reg;
   logic [IW-1:0]   idx_reg;
   logic            frame_done_reg;
   logic [PW-1:0]   head;
   logic            push, pop, byte_done, last_byte;

   function automatic logic [7:0] first_byte(input logic [PW-1:0] v);
      if (MSB_FIRST != 0) return v[PW-1 -: 8];
      else                return v[7:0];
   endfunction

   function automatic logic [PW-1:0] shift_out(input logic [PW-1:0] v);
      if (MSB_FIRST != 0) return v << 8;
      else                return v >> 8;
   endfunction

   assign in_ready   = (count_reg != CW'(DEPTH));
   assign push       = in_valid && in_ready;
   assign pop        = (state_reg == IDLE) && (count_reg != '0);
   assign byte_done  = (state_reg == DONE) && !tx_busy;
   assign last_byte  = (idx_reg == IW'(F - 1));
   assign head       = mem[rd_ptr_reg];
   assign tx_data    = tx_data_reg;
   assign frame_done = frame_done_reg;
   assign fifo_count = count_reg;

   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr_reg] <= PW'(in_data);
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_reg <= IDLE;
      else          state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (count_reg != '0) state_next = SEND;
         SEND:    state_next = ACK;
         ACK:     if (tx_busy) state_next = DONE;
         DONE:    if (!tx_busy) state_next = last_byte ? IDLE : SEND;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      tx_start = (state_reg == SEND);
      active   = (state_reg != IDLE);
   end

   // The checksum accumulates each payload byte as it is loaded into tx_data.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         shift_reg      <= '0;
         tx_data_reg    <= 8'h00;
         csum_reg       <= 8'h00;
         idx_reg        <= '0;
         frame_done_reg <= 1'b0;
      end else begin
         frame_done_reg <= byte_done && last_byte;
         if (pop) begin
            idx_reg <= '0;
            if (HEADER_EN != 0) begin
               tx_data_reg <= HEADER_BYTE;
               shift_reg   <= head;
               csum_reg    <= 8'h00;
            end else begin
               tx_data_reg <= first_byte(head);
               shift_reg   <= shift_out(head);
               csum_reg    <= first_byte(head);
            end
         end else if (byte_done && !last_byte) begin
            idx_reg <= idx_reg + 1'b1;
            if ((idx_reg + 1'b1) < IW'(PAY_END)) begin
               tx_data_reg <= first_byte(shift_reg);
               shift_reg   <= shift_out(shift_reg);
               csum_reg    <= csum_reg ^ first_byte(shift_reg);
            end else begin
               tx_data_reg <= csum_reg;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_result_framer.sv
// Directed bench for alu_result_framer: three parameterisations, each driven
// into a simple UART busy model that records every byte and its start cycle.
module tb_alu_result_framer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n = 1'b1;
   logic [2:0]  in_valid_v = '0;
   logic [2:0]  in_ready_v, tx_start_v, busy_v, fd_v, active_v;
   logic [15:0] in_data0 = '0, in_data1 = '0;
   logic [11:0] in_data2 = '0;
   logic [7:0]  txd [3];
   logic [2:0]  cnt0, cnt1, cnt2;
   int          blen [3];
   int          cyc = 0;
   int          max_cnt0 = 0;
   int          tests = 0, fails = 0;

   alu_result_framer dut0 (
      .clock(clk), .reset_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
      .in_data(in_data0), .tx_start(tx_start_v[0]), .tx_data(txd[0]), .tx_busy(busy_v[0]),
      .frame_done(fd_v[0]), .fifo_count(cnt0), .active(active_v[0]));

   alu_result_framer #(.MSB_FIRST(0), .HEADER_EN(0), .CHECKSUM_EN(0)) dut1 (
      .clock(clk), .reset_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
      .in_data(in_data1), .tx_start(tx_start_v[1]), .tx_data(txd[1]), .tx_busy(busy_v[1]),
      .frame_done(fd_v[1]), .fifo_count(cnt1), .active(active_v[1]));

   alu_result_framer #(.RESULT_W(12)) dut2 (
      .clock(clk), .reset_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
      .in_data(in_data2), .tx_start(tx_start_v[2]), .tx_data(txd[2]), .tx_busy(busy_v[2]),
      .frame_done(fd_v[2]), .fifo_count(cnt2), .active(active_v[2]));

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (int'(cnt0) > max_cnt0) max_cnt0 <= int'(cnt0);
   end

   // UART model: busy rises the cycle after tx_start and stays high blen cycles.
   for (genvar gi = 0; gi < 3; gi++) begin : g_uart
      int         cnt = 0;
      int         n = 0;
      int         fdn = 0;
      logic [7:0] cap [64];
      int         cap_t [64];
      assign busy_v[gi] = (cnt != 0);
      always @(posedge clk) begin
         if (tx_start_v[gi]) begin
            cnt <= blen[gi];
            if (n < 64) begin
               cap[n]   <= txd[gi];
               cap_t[n] <= cyc;
            end
            n <= n + 1;
         end else if (cnt != 0) begin
            cnt <= cnt - 1;
         end
         if (fd_v[gi]) fdn <= fdn + 1;
      end
   end

   function automatic int n_of(input int d);
      case (d)
         0:       return g_uart[0].n;
         1:       return g_uart[1].n;
         default: return g_uart[2].n;
      endcase
   endfunction

   function automatic int fdn_of(input int d);
      case (d)
         0:       return g_uart[0].fdn;
         1:       return g_uart[1].fdn;
         default: return g_uart[2].fdn;
      endcase
   endfunction

   function automatic logic [7:0] cap_of(input int d, input int k);
      case (d)
         0:       return g_uart[0].cap[k];
         1:       return g_uart[1].cap[k];
         default: return g_uart[2].cap[k];
      endcase
   endfunction

   function automatic int capt_of(input int d, input int k);
      case (d)
         0:       return g_uart[0].cap_t[k];
         1:       return g_uart[1].cap_t[k];
         default: return g_uart[2].cap_t[k];
      endcase
   endfunction

   task automatic push_val(input int d, input logic [15:0] v);
      @(negedge clk);
      case (d)
         0:       begin in_valid_v[0] = 1'b1; in_data0 = v; end
         1:       begin in_valid_v[1] = 1'b1; in_data1 = v; end
         default: begin in_valid_v[2] = 1'b1; in_data2 = v[11:0]; end
      endcase
      @(posedge clk);
      #1;
      in_valid_v = '0;
   endtask

   task automatic wait_fd(input int d, input int target);
      int k = 0;
      while (fdn_of(d) < target && k < 3000) begin
         @(posedge clk);
         k++;
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      blen[0] = 10; blen[1] = 10; blen[2] = 4;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      tests++; if (in_ready_v[0] !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b, required 1", in_ready_v[0]); end
      tests++; if (tx_start_v[0] !== 1'b0) begin fails++; $display("FAIL reset_tx_start: got %b, required 0", tx_start_v[0]); end
      tests++; if (txd[0] !== 8'h00) begin fails++; $display("FAIL reset_tx_data: got %02h, required 00", txd[0]); end
      tests++; if (fd_v[0] !== 1'b0) begin fails++; $display("FAIL reset_frame_done: got %b, required 0", fd_v[0]); end
      tests++; if (active_v[0] !== 1'b0) begin fails++; $display("FAIL reset_active: got %b, required 0", active_v[0]); end
      tests++; if (cnt0 !== 3'd0) begin fails++; $display("FAIL reset_fifo_count: got %0d, required 0", cnt0); end
      rst_n = 1'b1;
      $display("[TB] test_reset done");
   endtask

   task automatic test_default_frame;
      logic [7:0] exp [4] = '{8'hA5, 8'h12, 8'h34, 8'h26};
      int bn = n_of(0);
      int bf = fdn_of(0);
      @(negedge clk);
      in_valid_v[0] = 1'b1; in_data0 = 16'h1234;
      @(posedge clk); #1;
      in_valid_v[0] = 1'b0;
      tests++; if (cnt0 !== 3'd1) begin fails++; $display("FAIL default_count_after_push: got %0d, required 1", cnt0); end
      tests++; if (tx_start_v[0] !== 1'b0) begin fails++; $display("FAIL default_no_fallthrough: tx_start %b, required 0", tx_start_v[0]); end
      @(posedge clk); #1;
      tests++; if (tx_start_v[0] !== 1'b1 || txd[0] !== 8'hA5) begin fails++; $display("FAIL default_first_start: tx_start %b data %02h, required 1 A5", tx_start_v[0], txd[0]); end
      tests++; if (cnt0 !== 3'd0 || active_v[0] !== 1'b1) begin fails++; $display("FAIL default_pop: count %0d active %b, required 0 1", cnt0, active_v[0]); end
      @(posedge clk); #1;
      tests++; if (tx_start_v[0] !== 1'b0) begin fails++; $display("FAIL default_start_width: tx_start %b, required 0", tx_start_v[0]); end
      wait_fd(0, bf + 1);
      tests++; if (n_of(0) - bn !== 4) begin fails++; $display("FAIL default_starts: got %0d, required 4", n_of(0) - bn); end
      tests++; if (fdn_of(0) - bf !== 1) begin fails++; $display("FAIL default_frame_done: got %0d cycles, required 1", fdn_of(0) - bf); end
      for (int b = 0; b < 4; b++) begin
         tests++; if (cap_of(0, bn + b) !== exp[b]) begin fails++; $display("FAIL default_byte%0d: got %02h, required %02h", b, cap_of(0, bn + b), exp[b]); end
      end
      for (int b = 0; b < 3; b++) begin
         tests++; if (capt_of(0, bn + b + 1) - capt_of(0, bn + b) !== 12) begin fails++; $display("FAIL default_spacing%0d: got %0d, required 12", b, capt_of(0, bn + b + 1) - capt_of(0, bn + b)); end
      end
      tests++; if (cnt0 !== 3'd0 || active_v[0] !== 1'b0) begin fails++; $display("FAIL default_idle: count %0d active %b, required 0 0", cnt0, active_v[0]); end
      $display("[TB] test_default_frame done");
   endtask

   task automatic test_lsb_bare;
      int bn = n_of(1);
      int bf = fdn_of(1);
      int k = 0;
      push_val(1, 16'hBEEF);
      while (fdn_of(1) == bf && k < 500) begin @(posedge clk); k++; end
      #1;
      tests++; if (n_of(1) - bn !== 2) begin fails++; $display("FAIL lsb_bytes_at_done: got %0d, required 2", n_of(1) - bn); end
      wait_fd(1, bf + 1);
      tests++; if (cap_of(1, bn) !== 8'hEF) begin fails++; $display("FAIL lsb_byte0: got %02h, required EF", cap_of(1, bn)); end
      tests++; if (cap_of(1, bn + 1) !== 8'hBE) begin fails++; $display("FAIL lsb_byte1: got %02h, required BE", cap_of(1, bn + 1)); end
      tests++; if (fdn_of(1) - bf !== 1 || n_of(1) - bn !== 2) begin fails++; $display("FAIL lsb_totals: frame_done %0d starts %0d, required 1 2", fdn_of(1) - bf, n_of(1) - bn); end
      $display("[TB] test_lsb_bare done");
   endtask

   task automatic test_narrow;
      logic [7:0] exp [4] = '{8'hA5, 8'h0A, 8'hBC, 8'hB6};
      int bn = n_of(2);
      int bf = fdn_of(2);
      push_val(2, 16'h0ABC);
      wait_fd(2, bf + 1);
      tests++; if (n_of(2) - bn !== 4) begin fails++; $display("FAIL narrow_starts: got %0d, required 4", n_of(2) - bn); end
      for (int b = 0; b < 4; b++) begin
         tests++; if (cap_of(2, bn + b) !== exp[b]) begin fails++; $display("FAIL narrow_byte%0d: got %02h, required %02h", b, cap_of(2, bn + b), exp[b]); end
      end
      $display("[TB] test_narrow done");
   endtask

   task automatic test_back_to_back;
      logic [15:0] vals [6] = '{16'h1001, 16'h2002, 16'h3003, 16'h4004, 16'h5005, 16'h6006};
      logic [7:0]  chk  [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      int bn = n_of(0);
      int bf = fdn_of(0);
      int k = 0;
      blen[0] = 20;
      push_val(0, vals[0]);
      for (int j = 1; j < 5; j++) begin
         @(negedge clk);
         in_valid_v[0] = 1'b1; in_data0 = vals[j];
         tests++; if (in_ready_v[0] !== 1'b1) begin fails++; $display("FAIL b2b_ready_push%0d: got %b, required 1", j, in_ready_v[0]); end
         @(posedge clk);
      end
      @(negedge clk);
      in_data0 = vals[5];
      tests++; if (cnt0 !== 3'd4 || in_ready_v[0] !== 1'b0) begin fails++; $display("FAIL b2b_full: count %0d ready %b, required 4 0", cnt0, in_ready_v[0]); end
      while (in_ready_v[0] !== 1'b1 && k < 1000) begin @(negedge clk); k++; end
      tests++; if (fdn_of(0) - bf !== 1 || cnt0 !== 3'd3) begin fails++; $display("FAIL b2b_held_until_pop: frames %0d count %0d, required 1 3", fdn_of(0) - bf, cnt0); end
      @(posedge clk); #1;
      in_valid_v[0] = 1'b0;
      tests++; if (cnt0 !== 3'd4) begin fails++; $display("FAIL b2b_late_accept: count %0d, required 4", cnt0); end
      wait_fd(0, bf + 6);
      tests++; if (n_of(0) - bn !== 24) begin fails++; $display("FAIL b2b_starts: got %0d, required 24", n_of(0) - bn); end
      for (int f = 0; f < 6; f++) begin
         tests++;
         if (cap_of(0, bn + 4*f) !== 8'hA5 || cap_of(0, bn + 4*f + 1) !== vals[f][15:8] ||
             cap_of(0, bn + 4*f + 2) !== vals[f][7:0] || cap_of(0, bn + 4*f + 3) !== chk[f]) begin
            fails++;
            $display("FAIL b2b_frame%0d: got %02h %02h %02h %02h, required A5 %02h %02h %02h", f,
                     cap_of(0, bn + 4*f), cap_of(0, bn + 4*f + 1), cap_of(0, bn + 4*f + 2),
                     cap_of(0, bn + 4*f + 3), vals[f][15:8], vals[f][7:0], chk[f]);
         end
      end
      tests++; if (max_cnt0 > 4) begin fails++; $display("FAIL b2b_max_count: got %0d, required <= 4", max_cnt0); end
      $display("[TB] test_back_to_back done");
   endtask

   task automatic test_push_pop;
      logic [15:0] vals [4] = '{16'h0A0B, 16'h1C1D, 16'h2E2F, 16'h3132};
      int bn = n_of(0);
      int bf = fdn_of(0);
      int k = 0;
      blen[0] = 3;
      push_val(0, vals[0]);
      push_val(0, vals[1]);
      push_val(0, vals[2]);
      @(negedge clk);
      while (active_v[0] !== 1'b0 && k < 500) begin @(negedge clk); k++; end
      in_valid_v[0] = 1'b1; in_data0 = vals[3];
      tests++; if (cnt0 !== 3'd2) begin fails++; $display("FAIL pushpop_pre_count: got %0d, required 2", cnt0); end
      @(posedge clk); #1;
      in_valid_v[0] = 1'b0;
      tests++; if (cnt0 !== 3'd2 || tx_start_v[0] !== 1'b1) begin fails++; $display("FAIL pushpop_count: count %0d tx_start %b, required 2 1", cnt0, tx_start_v[0]); end
      wait_fd(0, bf + 4);
      for (int f = 0; f < 4; f++) begin
         tests++;
         if (cap_of(0, bn + 4*f + 1) !== vals[f][15:8] || cap_of(0, bn + 4*f + 2) !== vals[f][7:0]) begin
            fails++;
            $display("FAIL pushpop_order%0d: got %02h%02h, required %04h", f,
                     cap_of(0, bn + 4*f + 1), cap_of(0, bn + 4*f + 2), vals[f]);
         end
      end
      $display("[TB] test_push_pop done");
   endtask

   task automatic test_reset_midframe;
      logic [7:0] exp [4] = '{8'hA5, 8'h77, 8'h88, 8'hFF};
      int bn = n_of(0);
      int bf, bn2;
      int k = 0;
      blen[0] = 10;
      push_val(0, 16'h5566);
      push_val(0, 16'h1357);
      push_val(0, 16'h2468);
      while (n_of(0) < bn + 3 && k < 500) begin @(posedge clk); k++; end
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      tests++; if (tx_start_v[0] !== 1'b0 || txd[0] !== 8'h00 || fd_v[0] !== 1'b0) begin fails++; $display("FAIL midreset_tx: start %b data %02h done %b, required 0 00 0", tx_start_v[0], txd[0], fd_v[0]); end
      tests++; if (active_v[0] !== 1'b0 || cnt0 !== 3'd0 || in_ready_v[0] !== 1'b1) begin fails++; $display("FAIL midreset_state: active %b count %0d ready %b, required 0 0 1", active_v[0], cnt0, in_ready_v[0]); end
      bf = fdn_of(0);
      bn2 = n_of(0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (60) @(posedge clk);
      #1;
      tests++; if (n_of(0) !== bn2 || fdn_of(0) !== bf) begin fails++; $display("FAIL midreset_quiet: starts %0d frames %0d, required 0 0", n_of(0) - bn2, fdn_of(0) - bf); end
      push_val(0, 16'h7788);
      wait_fd(0, bf + 1);
      for (int b = 0; b < 4; b++) begin
         tests++; if (cap_of(0, bn2 + b) !== exp[b]) begin fails++; $display("FAIL midreset_new_byte%0d: got %02h, required %02h", b, cap_of(0, bn2 + b), exp[b]); end
      end
      $display("[TB] test_reset_midframe done");
   endtask

   initial begin
      test_reset();
      test_default_frame();
      test_lsb_bare();
      test_narrow();
      test_back_to_back();
      test_push_pop();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
